// File: rtl/gups_arb_rr.sv
// Round-robin N-channel memory arbiter for the GUPS top.
// Ports: clk/reset, client buses *_a, memory port, gnt, cnt, busy.
module gups_arb_rr #(
  parameter int NCH  = 4,
  parameter int AW   = 64,
  parameter int DW   = 64,
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*AW-1:0] addr_a,
  input  logic [NCH*DW-1:0] dout_a,
  output logic [NCH*DW-1:0] din_a,
  input  logic [NCH-1:0]    req_a,
  input  logic [NCH-1:0]    wr_a,
  output logic [NCH-1:0]    rdy_a,
  input  logic [NCH-1:0]    en,
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              req,
  output logic              wr,
  input  logic              rdy,
  output logic [NCH-1:0]    gnt,
  output logic [NCH*CNTW-1:0] cnt,
  output logic              busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  sel;
  logic [PW-1:0]  nxt;
  logic [NCH-1:0] elig;
  logic [PW-1:0]  pick;
  logic [PW-1:0]  pick_hi;
  logic [PW-1:0]  pick_lo;
  logic           hit_hi;
  logic           hit_lo;

  assign elig = req_a & en;
  assign nxt  = (sel == PW'(NCH - 1)) ? '0 : sel + 1'b1;

  // Rotating priority as two scans: first eligible at or above
  // ptr, else wrap around to the lowest eligible index.
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit_hi && elig[i] && (PW'(i) >= ptr)) begin
        hit_hi  = 1'b1;
        pick_hi = PW'(i);
      end
      if (!hit_lo && elig[i]) begin
        hit_lo  = 1'b1;
        pick_lo = PW'(i);
      end
    end
    pick = hit_hi ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      sel   <= '0;
      addr  <= '0;
      dout  <= '0;
      req   <= 1'b0;
      wr    <= 1'b0;
      gnt   <= '0;
      rdy_a <= '0;
      din_a <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|elig) begin
            addr  <= addr_a[pick*AW +: AW];
            dout  <= dout_a[pick*DW +: DW];
            wr    <= wr_a[pick];
            req   <= 1'b1;
            gnt   <= NCH'(1) << pick;
            sel   <= pick;
            busy  <= 1'b1;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (rdy) begin
            req   <= 1'b0;
            wr    <= 1'b0;
            din_a[sel*DW +: DW] <= din;
            rdy_a[sel] <= 1'b1;
            cnt[sel*CNTW +: CNTW] <=
              cnt[sel*CNTW +: CNTW] + CNTW'(1);
            ptr   <= nxt;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          // Idle outputs go back to their reset values;
          // no arbitration here so the client can drop req_a.
          rdy_a <= '0;
          gnt   <= '0;
          addr  <= '0;
          dout  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gups_arb_rr.sv
// Directed self-checking bench for gups_arb_rr.
// Covers a 4-channel and an 8-channel/4-bit-counter instance.
module tb_gups_arb_rr;

  logic         clk;
  logic         reset;
  logic [255:0] addr_a, dout_a, din_a;
  logic [3:0]   req_a, wr_a, rdy_a, en, gnt;
  logic [63:0]  addr, dout, din;
  logic         req, wr, rdy, busy;
  logic [127:0] cnt;

  logic [511:0] addr_a8, dout_a8, din_a8;
  logic [7:0]   req_a8, wr_a8, rdy_a8, en8, gnt8;
  logic [63:0]  addr8, dout8, din8;
  logic         req8, wr8, rdy8, busy8;
  logic [31:0]  cnt8;

  gups_arb_rr #(.NCH(4), .AW(64), .DW(64), .CNTW(32)) dut (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .dout_a(dout_a), .din_a(din_a),
    .req_a(req_a), .wr_a(wr_a), .rdy_a(rdy_a), .en(en),
    .addr(addr), .dout(dout), .din(din),
    .req(req), .wr(wr), .rdy(rdy),
    .gnt(gnt), .cnt(cnt), .busy(busy)
  );

  gups_arb_rr #(.NCH(8), .AW(64), .DW(64), .CNTW(4)) dut8 (
    .clk(clk), .reset(reset),
    .addr_a(addr_a8), .dout_a(dout_a8), .din_a(din_a8),
    .req_a(req_a8), .wr_a(wr_a8), .rdy_a(rdy_a8), .en(en8),
    .addr(addr8), .dout(dout8), .din(din8),
    .req(req8), .wr(wr8), .rdy(rdy8),
    .gnt(gnt8), .cnt(cnt8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  // Memory: rdy after lat cycles of req, din = addr ^ 'hDEED.
  initial begin
    int w, w8;
    w = 0; w8 = 0;
    rdy = 1'b0; din = '0;
    rdy8 = 1'b0; din8 = '0;
    forever begin
      @(negedge clk);
      rdy = 1'b0;
      if (req) begin
        w++;
        if (w >= lat) begin
          rdy = 1'b1;
          din = addr ^ 64'hDEED;
          w = 0;
        end
      end else w = 0;
      rdy8 = 1'b0;
      if (req8) begin
        w8++;
        if (w8 >= 1) begin
          rdy8 = 1'b1;
          din8 = addr8 ^ 64'hDEED;
          w8 = 0;
        end
      end else w8 = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic req_q;
  int   gap;
  int   glog[$];
  int   gaps[$];
  int   pulses[4];

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        if (r != -1) return -2;
        r = i;
      end
    return r;
  endfunction

  task automatic clear_mon();
    glog.delete();
    gaps.delete();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    gap = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (req && !req_q) begin
      if (glog.size() > 0) gaps.push_back(gap);
      glog.push_back(oh2i(gnt));
    end
    if (!req) gap++;
    else gap = 0;
    req_q = req;
    for (int i = 0; i < 4; i++)
      if (rdy_a[i]) pulses[i]++;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && busy; n++) step();
    chk(tag, busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_q = 1'b0;
    clear_mon();
  endtask

  initial begin
    int g8, p8, px8;
    logic r8q;
    reset = 1'b1;
    req_a = '0; wr_a = '0; en = 4'hF;
    addr_a = '0; dout_a = '0;
    req_a8 = '0; wr_a8 = '0; en8 = 8'hFF;
    addr_a8 = '0; dout_a8 = '0;
    req_q = 1'b0;
    clear_mon();
    #3;
    chk("rst_req", req, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cnt, 128'h0);
    chk("rst_rdy_a", rdy_a, 4'h0);
    chk("rst_din_a", |din_a, 1'b0);
    chk("rst_addr", addr, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single read on channel 2, memory latency 3
    lat = 3;
    addr_a[2*64 +: 64] = 64'h40;
    req_a = 4'b0100;
    step();
    chk("t1_req", req, 1'b1);
    chk("t1_addr", addr, 64'h40);
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_busy", busy, 1'b1);
    chk("t1_wr", wr, 1'b0);
    step();
    chk("t1_gnt_hold", gnt, 4'b0100);
    for (int n = 0; n < 20 && rdy_a == 0; n++) step();
    chk("t1_rdy_a", rdy_a, 4'b0100);
    chk("t1_din_a", din_a[2*64 +: 64], 64'hDEAD);
    chk("t1_cnt", cnt[2*32 +: 32], 32'd1);
    chk("t1_req_lo", req, 1'b0);
    req_a = '0;
    step();
    chk("t1_rdy_a_lo", rdy_a, 4'h0);
    chk("t1_gnt_lo", gnt, 4'h0);
    step();
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_addr", addr, 64'h0);
    chk("t1_pulses", pulses[2], 1);
    chk("t1_din_hold", din_a[2*64 +: 64], 64'hDEAD);

    // fairness, all four requesting, latency 1
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++)
      addr_a[i*64 +: 64] = 64'(i) << 8;
    req_a = 4'hF;
    for (int n = 0; n < 200 && glog.size() < 8; n++) step();
    req_a = '0;
    drain("t2_drain");
    chk("t2_ngrant", glog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_order%0d", i),
          (i < glog.size()) ? glog[i] : -1, i % 4);
    chk("t2_ngap", gaps.size(), 7);
    foreach (gaps[i])
      chk($sformatf("t2_gap%0d", i), gaps[i], 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_cnt%0d", i), cnt[i*32 +: 32], 32'd2);
      chk($sformatf("t2_pulse%0d", i), pulses[i], 2);
    end

    // enable mask 1010
    clear_mon();
    en = 4'b1010;
    req_a = 4'hF;
    for (int n = 0; n < 200 && glog.size() < 4; n++) step();
    req_a = '0;
    drain("t3_drain");
    chk("t3_ngrant", glog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i),
          (i < glog.size()) ? glog[i] : -1,
          (i % 2 == 0) ? 1 : 3);
    chk("t3_pulse0", pulses[0], 0);
    chk("t3_pulse1", pulses[1], 2);
    chk("t3_pulse2", pulses[2], 0);
    chk("t3_pulse3", pulses[3], 2);
    en = 4'hF;

    // channel-1 write, client drops req/en mid-transaction
    clear_mon();
    lat = 5;
    addr_a[1*64 +: 64] = 64'h1234;
    dout_a[1*64 +: 64] = 64'hBEEF;
    wr_a = 4'b0010;
    req_a = 4'b0010;
    step();
    chk("t4_req", req, 1'b1);
    chk("t4_wr", wr, 1'b1);
    chk("t4_gnt", gnt, 4'b0010);
    chk("t4_addr", addr, 64'h1234);
    chk("t4_dout", dout, 64'hBEEF);
    en = 4'b1101;
    req_a = '0;
    wr_a = '0;
    step();
    step();
    chk("t4_req_hold", req, 1'b1);
    chk("t4_wr_hold", wr, 1'b1);
    chk("t4_gnt_hold", gnt, 4'b0010);
    for (int n = 0; n < 20 && rdy_a == 0; n++) step();
    chk("t4_rdy_a", rdy_a, 4'b0010);
    chk("t4_wr_lo", wr, 1'b0);
    drain("t4_drain");
    chk("t4_pulse1", pulses[1], 1);
    chk("t4_cnt1", cnt[1*32 +: 32], 32'd5);
    en = 4'hF;

    // reset during BUSY on channel 3 (ptr is 2 here)
    clear_mon();
    lat = 10;
    req_a = 4'b1000;
    step();
    chk("t5_gnt", gnt, 4'b1000);
    chk("t5_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_req", req, 1'b0);
    chk("t5_gnt0", gnt, 4'h0);
    chk("t5_busy0", busy, 1'b0);
    chk("t5_cnt0", cnt, 128'h0);
    #2;
    reset = 1'b0;
    lat = 1;
    req_a = 4'b1001;
    step();
    chk("t5_regrant", gnt, 4'b0001);
    req_a = '0;
    drain("t5_drain");

    // 8-channel, 4-bit counters, channel 5 alone x17
    for (int i = 0; i < 8; i++)
      addr_a8[i*64 +: 64] = (64'(i) << 8) | 64'h50;
    req_a8 = 8'b0010_0000;
    g8 = 0; p8 = 0; px8 = 0; r8q = 1'b0;
    for (int n = 0; n < 400 && g8 < 17; n++) begin
      @(posedge clk);
      #1;
      if (req8 && !r8q) begin
        g8++;
        if (g8 == 1) begin
          chk("t6_addr", addr8, 64'h550);
          chk("t6_gnt", gnt8, 8'b0010_0000);
        end
      end
      r8q = req8;
      if (rdy_a8[5]) p8++;
      if ((rdy_a8 & 8'b1101_1111) != 0) px8++;
      if (g8 == 17) req_a8 = '0;
    end
    for (int n = 0; n < 40 && busy8; n++) begin
      @(posedge clk);
      #1;
      if (rdy_a8[5]) p8++;
      if ((rdy_a8 & 8'b1101_1111) != 0) px8++;
    end
    chk("t6_idle", busy8, 1'b0);
    chk("t6_ngrant", g8, 17);
    chk("t6_pulses", p8, 17);
    chk("t6_others", px8, 0);
    chk("t6_cnt5", cnt8[5*4 +: 4], 4'd1);
    chk("t6_cnt4", cnt8[4*4 +: 4], 4'd0);
    chk("t6_din5", din_a8[5*64 +: 64], 64'hDBBD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
